sha512_ctrl: RTL and testbench
==============================

SHA512_CTRL -- requirements
Module: sha512_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent in RUN waiting for core_done before aborting (legal range 100..1023).
REQ-002 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in_valid  input  1  SHALL flag that a padded 1024-bit message chunk is present.
REQ-005 in_ready  output  1  SHALL flag that a chunk is accepted this cycle.
REQ-006 in_chunk  input  1024  SHALL carry the chunk, first message byte in bits [1023:1016].
REQ-007 in_last  input  1  SHALL mark the final chunk of a message; sampled with in_chunk.
REQ-008 out_valid  output  1  SHALL flag that a digest is presented.
REQ-009 out_ready  input  1  SHALL flag that the sink takes the digest.
REQ-010 out_digest  output  512  SHALL carry H0..H7, H0 in bits [511:448].
REQ-011 busy  output  1  SHALL be high in any state other than IDLE.
REQ-012 err  output  1  SHALL be the sticky timeout flag.
REQ-013 core_reset_n  output  1  SHALL drive the compression core's active-low restart.
REQ-014 core_chunk  output  1024  SHALL drive the core's chunk input.
REQ-015 core_iH  output  512  SHALL drive the core's input hash, word 0 in the MSBs.
REQ-016 core_oH  input  512  SHALL receive the core's output hash, same layout.
REQ-017 core_done  input  1  SHALL receive the core's done level.

Function
REQ-018 FSM states: IDLE, START, RUN, OUT.
- IDLE->START on in_valid&&in_ready.
- START->RUN unconditionally.
- RUN->OUT on core_done with last_reg=1.
- RUN->IDLE on core_done with last_reg=0.
- RUN->IDLE on timeout.
- OUT->IDLE on out_ready.
REQ-019 in_ready SHALL equal (state==IDLE); it SHALL be 0 in START, RUN and OUT, and in_valid there SHALL be ignored.
REQ-020 On acceptance, in_chunk and in_last SHALL be captured into chunk_reg and last_reg; core_chunk SHALL equal chunk_reg and SHALL be stable from START through RUN exit.
REQ-021 The hash register H (8x64) SHALL drive core_iH and SHALL hold the SHA-512 IV when no message is in progress: 6a09e667f3bcc908, bb67ae8584caa73b, 3c6ef372fe94f82b, a54ff53a5f1d36f1, 510e527fade682d1, 9b05688c2b3e6c1f, 1f83d9abfb41bd6b, 5be0cd19137e2179.
REQ-022 core_reset_n SHALL be a flop loaded with (next_state==RUN), so it is high exactly while state==RUN, with no combinational path to any input.
REQ-023 In RUN, H SHALL be loaded from core_oH on the cycle core_done is first seen high; H SHALL NOT change during RUN otherwise, because core_oH depends combinationally on core_iH.
REQ-024 In OUT, out_valid SHALL be 1 and out_digest SHALL equal H, held stable until out_ready; on out_valid&&out_ready, H SHALL reload the IV.
REQ-025 out_digest SHALL equal H at all times; consumers SHALL qualify it with out_valid.
REQ-026 A cycle counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-027 If the counter reaches TIMEOUT without core_done:
- err SHALL be set to 1;
- H SHALL reload the IV;
- the current message SHALL be discarded and the FSM SHALL go to IDLE.
REQ-028 err SHALL stay set until reset; subsequent messages SHALL still be processed.
REQ-029 If core_done and timeout occur in the same cycle, core_done SHALL win.
REQ-030 Chunk-to-chunk throughput SHALL be one chunk per (core latency + 3) cycles: accept, START, RUN, back to IDLE.

Reset
REQ-031 While reset is low, the block SHALL hold these values:
- state = IDLE, H = IV, in_ready = 1;
- out_valid = 0, busy = 0, err = 0;
- core_reset_n = 0, last_reg = 0, counter = 0, chunk_reg = 0.
REQ-032 Reset asserted mid-message SHALL abort it and return the block to the REQ-031 values asynchronously; no digest SHALL be emitted for the aborted message.

Verification
REQ-033 One-chunk padded "abc" with in_last=1 -> out_digest = ddaf35a193617aba...a54ca49f (full FIPS 180-4 value); out_valid rises once; err=0.
REQ-034 Two-chunk FIPS 896-bit "abcdefghbcdefghi..." message with in_last only on chunk 2 -> digest 8e959b75dae313da...874be909; in_ready=0 from chunk-1 acceptance until RUN exit.
REQ-035 out_ready held low for 20 cycles, then pulsed -> digest stable throughout, in_ready=0, H returns to IV the cycle after the handshake; back-to-back "abc" then yields the identical digest.
REQ-036 Reset pulsed low during RUN of chunk 1 of 2 -> immediately IDLE, H=IV, core_reset_n=0; then "abc" -> correct digest.
REQ-037 Stub core with core_done tied 0, TIMEOUT=255 -> err=1 exactly 255 RUN cycles after RUN entry; FSM in IDLE; out_valid never asserted.
REQ-038 Random in_valid gaps and out_ready stalls over 50 random messages of 1-4 chunks -> every digest matches the reference model; core_reset_n never high outside RUN.

Source files
------------

// File: rtl/sha512_ctrl.sv
// SHA-512 chunk sequencer: feeds padded 1024-bit chunks to an external compression core,
// chains the intermediate hash and presents the final digest with a ready/valid handshake.
module sha512_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_chunk,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [511:0]  out_digest,
    output logic          busy,
    output logic          err,
    output logic          core_reset_n,
    output logic [1023:0] core_chunk,
    output logic [511:0]  core_iH,
    input  logic [511:0]  core_oH,
    input  logic          core_done
);

    localparam int unsigned CHUNK_W = 1024;
    localparam int unsigned HASH_W  = 512;
    localparam int unsigned CNT_W   = 10;

    localparam logic [HASH_W-1:0] IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic               last_q, last_d;
    logic [HASH_W-1:0]  h_q, h_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               core_reset_n_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    // Next-state logic; H only moves on core_done, timeout or digest handoff.
    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        last_d  = last_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    chunk_d = in_chunk;
                    last_d  = in_last;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // core_done takes priority over a coincident timeout
                if (core_done) begin
                    h_d     = core_oH;
                    state_d = last_q ? S_OUT : S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    h_d     = IV;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    h_d     = IV;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; handshake/core controls are decoded from next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            chunk_q        <= '0;
            last_q         <= 1'b0;
            h_q            <= IV;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            core_reset_n_q <= 1'b0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            chunk_q        <= chunk_d;
            last_q         <= last_d;
            h_q            <= h_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            core_reset_n_q <= (state_d == S_RUN);
            in_ready_q     <= (state_d == S_IDLE);
            out_valid_q    <= (state_d == S_OUT);
            busy_q         <= (state_d != S_IDLE);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_digest   = h_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign core_reset_n = core_reset_n_q;
    assign core_chunk   = chunk_q;
    assign core_iH      = h_q;

endmodule

// File: tb/tb_sha512_ctrl.sv
// Bench for sha512_ctrl: behavioural SHA-512 compression core stub with programmable latency,
// known-answer vector table, scoreboard of expected digests, and multi-cycle corner sequences.
module tb_sha512_ctrl;

    localparam logic [511:0] IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [80*64-1:0] K_ALL = {
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [1023:0] ABC_CHUNK = {"abc", 8'h80, 984'h0, 8'h18};
    localparam logic [1023:0] M896_C0 = {
        "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu",
        8'h80, 120'h0};
    localparam logic [1023:0] M896_C1 = {1008'h0, 16'h0380};
    localparam logic [511:0] ABC_DIG = {
        64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
    localparam logic [511:0] M896_DIG = {
        64'h8e959b75dae313da, 64'h8cf4f72814fc143f, 64'h8f7779c6eb9f7fa1, 64'h7299aeadb6889018,
        64'h501d289e4900f7e4, 64'h331b99dec4b5433a, 64'hc7d329eeb6dd2654, 64'h5e96e55b874be909};

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_chunk;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [511:0]  out_digest;
    logic          busy;
    logic          err;
    logic          core_reset_n;
    logic [1023:0] core_chunk;
    logic [511:0]  core_iH;
    logic [511:0]  core_oH;
    logic          core_done;

    sha512_ctrl #(.TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_chunk(in_chunk), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest),
        .busy(busy), .err(err),
        .core_reset_n(core_reset_n), .core_chunk(core_chunk), .core_iH(core_iH),
        .core_oH(core_oH), .core_done(core_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [511:0] sha512_compress(input logic [1023:0] blk, input logic [511:0] hin);
        logic [63:0] w [80];
        logic [63:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[1023 - 64*i -: 64];
        for (int i = 16; i < 80; i++) begin
            s0 = rotr(w[i-15], 1) ^ rotr(w[i-15], 8) ^ (w[i-15] >> 7);
            s1 = rotr(w[i-2], 19) ^ rotr(w[i-2], 61) ^ (w[i-2] >> 6);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = hin[511:448]; b = hin[447:384]; c = hin[383:320]; d = hin[319:256];
        e = hin[255:192]; f = hin[191:128]; g = hin[127:64];  h = hin[63:0];
        for (int i = 0; i < 80; i++) begin
            t1 = h + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g))
                 + K_ALL[(79 - i)*64 +: 64] + w[i];
            t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[511:448] + a, hin[447:384] + b, hin[383:320] + c, hin[319:256] + d,
                hin[255:192] + e, hin[191:128] + f, hin[127:64] + g, hin[63:0] + h};
    endfunction

    function automatic logic [1023:0] rand_chunk();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // Compression core stub: done after core_lat RUN cycles, oH combinational from iH/chunk.
    logic [7:0] ccnt;
    logic [7:0] core_lat;
    logic       core_dead;

    always_ff @(posedge clk) begin
        if (!core_reset_n) ccnt <= 8'd0;
        else if (ccnt != 8'hff) ccnt <= ccnt + 8'd1;
    end

    assign core_done = !core_dead && core_reset_n && (ccnt >= core_lat);
    always_comb core_oH = sha512_compress(core_chunk, core_iH);

    // Sink ready: forced level or random stalls, updated just after each rising edge.
    logic rdy_mode;
    logic rdy_force;
    always @(posedge clk) begin
        #1;
        out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Passive monitor: handshake count and core control invariants.
    int            hs_cnt = 0;
    int            crn_bad = 0;
    int            chunk_bad = 0;
    logic [1023:0] acc_chunk = '0;
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) hs_cnt = hs_cnt + 1;
        if (reset && core_reset_n && (in_ready || out_valid || !busy)) crn_bad = crn_bad + 1;
        if (reset && core_reset_n && (core_chunk !== acc_chunk)) chunk_bad = chunk_bad + 1;
    end

    int checks = 0;
    int failures = 0;
    logic [511:0] exp_q [$];

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, req);
        end
    endtask

    task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Offer one chunk; waited = negedges seen with in_ready low before acceptance.
    task automatic send_chunk(input logic [1023:0] c, input logic l, output int waited);
        in_valid = 1'b1;
        in_chunk = c;
        in_last  = l;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 4000) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end
        acc_chunk = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_chunk = rand_chunk();
    endtask

    // Wait for the next digest handshake and compare it with the scoreboard head.
    task automatic collect(input string nm);
        logic [511:0] exp;
        int n;
        n = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!(out_valid && out_ready)) begin
            failures++;
            $display("FAIL %s_no_digest actual=none required=handshake", nm);
        end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected actual=%h required=none", nm, out_digest);
        end else begin
            exp = exp_q.pop_front();
            if (out_digest !== exp) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", nm, out_digest, exp);
            end
        end
    endtask

    typedef struct {
        string         name;
        int            nch;
        logic [1023:0] c0;
        logic [1023:0] c1;
        logic [511:0]  dig;
        logic [7:0]    lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int w, hs0, n, run, stall_bad;
        logic err_prev;
        logic [1023:0] mc [4];
        logic [511:0]  hm;

        vecs[0] = '{"abc_lat5",       1, ABC_CHUNK, '0,      ABC_DIG,  8'd5};
        vecs[1] = '{"fips896_lat3",   2, M896_C0,   M896_C1, M896_DIG, 8'd3};
        vecs[2] = '{"abc_lat0",       1, ABC_CHUNK, '0,      ABC_DIG,  8'd0};
        vecs[3] = '{"abc_done_at_to", 1, ABC_CHUNK, '0,      ABC_DIG,  8'd254};
        vecs[4] = '{"fips896_lat17",  2, M896_C0,   M896_C1, M896_DIG, 8'd17};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_chunk  = '0;
        in_last   = 1'b0;
        core_lat  = 8'd5;
        core_dead = 1'b0;
        rdy_mode  = 1'b0;
        rdy_force = 1'b1;
        #3 reset = 1'b0;

        // Values held while reset is low
        repeat (2) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_core_reset_n", core_reset_n, 1'b0);
        chkw("rst_out_digest", out_digest, IV);
        chkw("rst_core_iH", core_iH, IV);
        chk1("rst_core_chunk_zero", core_chunk == '0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer table
        for (int i = 0; i < 5; i++) begin
            core_lat = vecs[i].lat;
            hs0 = hs_cnt;
            exp_q.push_back(vecs[i].dig);
            if (vecs[i].nch == 1) begin
                send_chunk(vecs[i].c0, 1'b1, w);
            end else begin
                send_chunk(vecs[i].c0, 1'b0, w);
                send_chunk(vecs[i].c1, 1'b1, w);
                chkn({vecs[i].name, "_inready_low_cycles"}, w, int'(vecs[i].lat) + 2);
            end
            collect(vecs[i].name);
            repeat (3) @(negedge clk);
            chkn({vecs[i].name, "_handshakes"}, hs_cnt - hs0, 1);
            chk1({vecs[i].name, "_err"}, err, 1'b0);
            chkw({vecs[i].name, "_h_iv_after"}, out_digest, IV);
            @(posedge clk);
            #1;
        end

        // Sink stalls for 20 cycles; digest must hold, then H returns to IV
        core_lat = 8'd6;
        @(negedge clk);
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(ABC_DIG);
        send_chunk(ABC_CHUNK, 1'b1, w);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk1("stall_out_valid_seen", out_valid, 1'b1);
        stall_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_digest !== ABC_DIG || in_ready || !out_valid) stall_bad++;
            @(negedge clk);
        end
        chkn("stall_digest_stable", stall_bad, 0);
        rdy_force = 1'b1;
        collect("stall_digest");
        rdy_force = 1'b0;
        @(negedge clk);
        chkw("stall_h_iv_next_cycle", out_digest, IV);
        chk1("stall_out_valid_drop", out_valid, 1'b0);
        chk1("stall_in_ready_back", in_ready, 1'b1);
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(ABC_DIG);
        send_chunk(ABC_CHUNK, 1'b1, w);
        collect("back_to_back_abc");

        // Reset during RUN of chunk 1 of 2
        core_lat = 8'd20;
        @(posedge clk);
        #1;
        send_chunk(M896_C0, 1'b0, w);
        n = 0;
        while (!core_reset_n && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk1("abort_reached_run", core_reset_n, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_core_reset_n", core_reset_n, 1'b0);
        chkw("abort_h_iv", out_digest, IV);
        @(negedge clk);
        reset = 1'b1;
        hs0 = hs_cnt;
        @(posedge clk);
        #1;
        core_lat = 8'd4;
        exp_q.push_back(ABC_DIG);
        send_chunk(ABC_CHUNK, 1'b1, w);
        collect("after_abort_abc");
        repeat (3) @(negedge clk);
        chkn("after_abort_handshakes", hs_cnt - hs0, 1);

        // Dead core: timeout after exactly TIMEOUT RUN cycles
        chk1("err_before_timeout", err, 1'b0);
        core_dead = 1'b1;
        hs0 = hs_cnt;
        @(posedge clk);
        #1;
        send_chunk(ABC_CHUNK, 1'b1, w);
        n = 0;
        while (!core_reset_n && n < 50) begin
            n++;
            @(negedge clk);
        end
        run = 0;
        err_prev = 1'b0;
        do begin
            run++;
            err_prev = err;
            @(negedge clk);
        end while (core_reset_n && run < 2000);
        chkn("timeout_run_cycles", run, 255);
        chk1("timeout_err_prev", err_prev, 1'b0);
        chk1("timeout_err_set", err, 1'b1);
        chk1("timeout_idle", in_ready, 1'b1);
        chkw("timeout_h_iv", out_digest, IV);
        repeat (5) @(negedge clk);
        chkn("timeout_no_digest", hs_cnt - hs0, 0);
        core_dead = 1'b0;

        // Random messages with input gaps and sink stalls against the chained reference
        rdy_mode = 1'b1;
        @(posedge clk);
        #1;
        for (int m = 0; m < 50; m++) begin
            n = $urandom_range(1, 4);
            core_lat = 8'($urandom_range(0, 40));
            hm = IV;
            for (int k = 0; k < n; k++) begin
                mc[k] = rand_chunk();
                hm = sha512_compress(mc[k], hm);
            end
            exp_q.push_back(hm);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send_chunk(mc[k], k == n - 1, w);
            end
            collect("random_msg");
            @(posedge clk);
            #1;
        end
        repeat (5) @(negedge clk);
        chk1("err_sticky", err, 1'b1);
        chkn("scoreboard_empty", exp_q.size(), 0);
        chkn("core_reset_n_outside_run", crn_bad, 0);
        chkn("core_chunk_stable_in_run", chunk_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
